// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache with a lookup/refill FSM, sequenced
// invalidate-all and saturating hit/miss counters.
//
// Handshakes: cpu_req_i is held with cpu_addr_i stable until cpu_ack_o pulses
// for one cycle (cpu_hit_o qualifies it). mem_req_o/mem_addr_o are held until
// mem_ready_i is seen high, which completes the refill in that same cycle.
module icache_dm_param #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINES      = 128,
   parameter int LINE_WORDS = 4,
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cpu_req_i,
   input  logic [ADDR_W-1:0]            cpu_addr_i,
   output logic                         cpu_ack_o,
   output logic [DATA_W-1:0]            cpu_rdata_o,
   output logic                         cpu_hit_o,
   input  logic                         flush_i,
   output logic                         flush_busy_o,
   output logic                         mem_req_o,
   output logic [ADDR_W-1:0]            mem_addr_o,
   input  logic [DATA_W*LINE_WORDS-1:0] mem_rdata_i,
   input  logic                         mem_ready_i,
   output logic [CNT_W-1:0]             hit_count_o,
   output logic [CNT_W-1:0]             miss_count_o,
   output logic [2:0]                   dbg_state_o
);

   localparam int OFF_W     = $clog2(DATA_W / 8);
   localparam int WSEL_BITS = $clog2(LINE_WORDS);
   localparam int WSEL_W    = (WSEL_BITS > 0) ? WSEL_BITS : 1;
   localparam int IDX_W     = $clog2(LINES);
   localparam int LOW_W     = OFF_W + WSEL_BITS;
   localparam int TAG_W     = ADDR_W - LOW_W - IDX_W;
   localparam int LINE_W    = DATA_W * LINE_WORDS;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOOKUP  = 3'd1,
      S_REFILL  = 3'd2,
      S_RESPOND = 3'd3,
      S_FLUSH   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
   logic                  flush_pending_q, flush_pending_d;
   logic [IDX_W-1:0]      flush_idx_q, flush_idx_d;
   logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;
   logic [LINES-1:0]      valid_q, valid_d;
   logic [LINE_W-1:0]     data_q [LINES];
   logic [TAG_W-1:0]      tag_q [LINES];

   logic [IDX_W-1:0]                   req_idx;
   logic [TAG_W-1:0]                   req_tag;
   logic [WSEL_W-1:0]                  word_sel;
   logic [ADDR_W-1:0]                  line_addr;
   logic [LINE_WORDS-1:0][DATA_W-1:0]  cur_line;
   logic [DATA_W-1:0]                  sel_word;
   logic                               lookup_hit;
   logic                               refill_we;

   assign req_idx   = req_addr_q[LOW_W +: IDX_W];
   assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
   assign line_addr = req_addr_q & ({ADDR_W{1'b1}} << LOW_W);

   generate
      if (WSEL_BITS > 0) begin : g_wsel
         assign word_sel = req_addr_q[OFF_W +: WSEL_BITS];
      end else begin : g_no_wsel
         assign word_sel = '0;
      end
   endgenerate

   assign cur_line    = data_q[req_idx];
   assign sel_word    = cur_line[word_sel];
   assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign dbg_state_o = state_q;
   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;

   always_comb begin
      state_d         = state_q;
      req_addr_d      = req_addr_q;
      flush_pending_d = flush_pending_q;
      flush_idx_d     = flush_idx_q;
      hit_cnt_d       = hit_cnt_q;
      miss_cnt_d      = miss_cnt_q;
      valid_d         = valid_q;
      refill_we       = 1'b0;
      cpu_ack_o       = 1'b0;
      cpu_hit_o       = 1'b0;
      cpu_rdata_o     = '0;
      mem_req_o       = 1'b0;
      mem_addr_o      = '0;
      flush_busy_o    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (flush_i || flush_pending_q) begin
               state_d         = S_FLUSH;
               flush_idx_d     = '0;
               flush_pending_d = 1'b0;
            end else if (cpu_req_i) begin
               req_addr_d = cpu_addr_i;
               state_d    = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (lookup_hit) begin
               cpu_ack_o   = 1'b1;
               cpu_hit_o   = 1'b1;
               cpu_rdata_o = sel_word;
               if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
               // A flush waiting behind this request starts as soon as it retires.
               if (flush_i || flush_pending_q) begin
                  state_d         = S_FLUSH;
                  flush_idx_d     = '0;
                  flush_pending_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
               if (flush_i) flush_pending_d = 1'b1;
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            mem_req_o  = 1'b1;
            mem_addr_o = line_addr;
            if (flush_i) flush_pending_d = 1'b1;
            if (mem_ready_i) begin
               refill_we        = 1'b1;
               valid_d[req_idx] = 1'b1;
               state_d          = S_RESPOND;
            end
         end
         S_RESPOND: begin
            cpu_ack_o   = 1'b1;
            cpu_rdata_o = sel_word;
            if (flush_i || flush_pending_q) begin
               state_d         = S_FLUSH;
               flush_idx_d     = '0;
               flush_pending_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            flush_busy_o         = 1'b1;
            valid_d[flush_idx_q] = 1'b0;
            flush_idx_d          = flush_idx_q + 1'b1;
            if (flush_idx_q == IDX_W'(LINES - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         req_addr_q      <= '0;
         flush_pending_q <= 1'b0;
         flush_idx_q     <= '0;
         hit_cnt_q       <= '0;
         miss_cnt_q      <= '0;
         valid_q         <= '0;
      end else begin
         state_q         <= state_d;
         req_addr_q      <= req_addr_d;
         flush_pending_q <= flush_pending_d;
         flush_idx_q     <= flush_idx_d;
         hit_cnt_q       <= hit_cnt_d;
         miss_cnt_q      <= miss_cnt_d;
         valid_q         <= valid_d;
      end
   end

   // Line data and tags are left unreset so they can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (refill_we) begin
         data_q[req_idx] <= mem_rdata_i;
         tag_q[req_idx]  <= req_tag;
      end
   end

endmodule
